// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared definitions for the fetch prefetch queue: FSM states, reset PC,
// NOP encoding and FIFO entry layout.
package fetch_prefetch_queue_pkg;

  // Fetch FSM states. DISCARD means one request is still in flight, but its
  // data belongs to a path that a redirect has abandoned.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  // Queue entry is {pc[31:0], instr[31:0]}.
  localparam int ENTRY_W = 64;

  // Redirect targets are word aligned, so the byte-offset bits are cleared.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Generic synchronous FIFO with push, pop and flush, plus occupancy count.
// Read data is the head entry, available combinationally (zero latency).
// Flush has priority over push and pop. Pop on empty is ignored. Push on full
// is ignored unless a pop happens in the same cycle.
module sync_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  // Next-state pointers and count. DEPTH is a power of two, so the
  // pointers wrap naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array. It is not reset, because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetcher. It issues sequential word fetches to a multi-cycle
// instruction memory, buffers the returned words and presents the head to
// decode. A redirect flushes the queue and restarts fetching at the target.
//
// Memory handshake: imem_req_o/imem_addr_o are registered. Once imem_req_o
// rises, it stays high with a stable address until a rising edge where
// imem_ack_i=1. That edge completes the transfer and imem_rdata_i is
// captured. An ack while imem_req_o=0 is ignored. At most one request is
// outstanding, and a request is only launched when a queue slot is reserved
// for its data. A request is never abandoned: after a redirect, it completes
// in DISCARD and its data is dropped.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_rdata_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic             stall_i,
  output logic [31:0]      instr_f_o,
  output logic [31:0]      pc_plus_4_f_o,
  output logic             valid_f_o,
  output logic [CNT_W-1:0] count_o,
  output logic [1:0]       dbg_state_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  addr_q, addr_d;

  logic         ack_s, push_s, pop_s;
  logic         room_s;
  logic [31:0]  target_pc_s;
  logic [31:0]  pc_next_s;
  logic [CNT_W:0] cnt_after_s;

  logic [ENTRY_W-1:0] head_s;
  logic               fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]   fifo_count_s;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (redirect_i),
    .wdata_i ({addr_q, imem_rdata_i}),
    .rdata_o (head_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign imem_req_o  = (state_q != ST_IDLE);
  assign imem_addr_o = addr_q;
  assign dbg_state_o = state_q;
  assign count_o     = fifo_count_s;

  // The head entry drives decode directly. An empty queue shows a NOP.
  assign valid_f_o     = !fifo_empty_s;
  assign instr_f_o     = valid_f_o ? head_s[31:0] : NOP_INSTR;
  assign pc_plus_4_f_o = valid_f_o ? (head_s[63:32] + 32'd4) : 32'd0;

  // A completed transfer requires a live request. A redirect overrides pop
  // and push.
  assign ack_s  = imem_ack_i && imem_req_o;
  assign pop_s  = valid_f_o && !stall_i && !redirect_i;
  assign push_s = (state_q == ST_REQ) && ack_s && !redirect_i &&
                  (!fifo_full_s || pop_s);

  // Occupancy after this cycle's push/pop. A new request is only launched if
  // a slot is still free for its data.
  assign cnt_after_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, push_s}
                     - {{CNT_W{1'b0}}, pop_s};
  assign room_s      = (cnt_after_s < (CNT_W + 1)'(DEPTH));

  assign target_pc_s = align_word(redirect_pc_i);
  assign pc_next_s   = fetch_pc_q + 32'd4;

  // Next-state, next fetch PC and next request address.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = target_pc_s;
          addr_d     = target_pc_s;
          state_d    = ST_REQ;
        end else if (room_s) begin
          addr_d  = fetch_pc_q;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_i) begin
          fetch_pc_d = target_pc_s;
          if (ack_s) begin
            // The in-flight word is dropped and the target is fetched next.
            addr_d  = target_pc_s;
            state_d = ST_REQ;
          end else begin
            // The old request must still complete. Its data is discarded.
            state_d = ST_DISCARD;
          end
        end else if (ack_s) begin
          fetch_pc_d = pc_next_s;
          if (room_s) begin
            addr_d  = pc_next_s;
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (redirect_i) fetch_pc_d = target_pc_s;
        if (ack_s) begin
          addr_d  = redirect_i ? target_pc_s : fetch_pc_q;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, fetch PC and request address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

endmodule
